// File: rtl/mmio_interconnect_if.sv
// Bus bundle between the memory-bus master and the peripheral side of mmio_interconnect.
// The interconnect takes the slave modport (it is the slave of the master bus); the environment takes master.
interface mmio_interconnect_if #(
    parameter int NUM_SLAVES = 9
);
    logic [31:0]              address_in;
    logic                     read_in;
    logic                     write_in;
    logic [3:0]               write_mask_in;
    logic [31:0]              write_value_in;
    logic [31:0]              read_value_out;
    logic                     ready_out;
    logic [NUM_SLAVES-1:0]    sel_out;
    logic [NUM_SLAVES*32-1:0] slave_read_value_in;
    logic [NUM_SLAVES-1:0]    slave_ready_in;
    logic [3:0]               write_mask_out;
    logic [31:0]              write_value_out;

    modport slave (
        input  address_in, read_in, write_in, write_mask_in, write_value_in,
        input  slave_read_value_in, slave_ready_in,
        output read_value_out, ready_out, sel_out, write_mask_out, write_value_out
    );

    modport master (
        output address_in, read_in, write_in, write_mask_in, write_value_in,
        output slave_read_value_in, slave_ready_in,
        input  read_value_out, ready_out, sel_out, write_mask_out, write_value_out
    );
endinterface

// File: rtl/mmio_interconnect.sv
// Address-window decoder and read/ready mux between the memory bus and NUM_SLAVES peripherals,
// with an error completion for unmapped addresses, a wait-state watchdog and sticky error capture.
module mmio_interconnect #(
    parameter int                       NUM_SLAVES = 9,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0,
    parameter int                       TIMEOUT    = 255,
    parameter logic [31:0]              ERR_VALUE  = 32'hDEADBEEF
) (
    input  logic               clk,
    input  logic               reset,
    mmio_interconnect_if.slave bus,
    output logic               err_valid_out,
    output logic               err_timeout_out,
    output logic [31:0]        err_address_out,
    output logic [7:0]         err_count_out,
    input  logic               err_clear_in
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [IDX_W-1:0] winner;
    logic             access;
    logic             hit_any;
    logic             sel_active;
    logic             slave_ready;
    logic             err_enter;

    assign access = bus.read_in | bus.write_in;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        winner  = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.address_in & SLAVE_MASK[32*i +: 32]) ==
                (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32])) begin
                hit_any = 1'b1;
                winner  = IDX_W'(i);
            end
        end
    end

    assign sel_active  = access & hit_any & (state != ERR);
    assign slave_ready = bus.slave_ready_in[winner];
    assign err_enter   = (state_next == ERR);

    always_comb begin
        bus.sel_out        = '0;
        bus.write_mask_out = 4'h0;
        bus.ready_out      = 1'b0;
        bus.read_value_out = 32'h0;
        if (state == ERR) begin
            bus.ready_out      = 1'b1;
            bus.read_value_out = ERR_VALUE;
        end else if (sel_active) begin
            bus.sel_out[winner] = 1'b1;
            bus.write_mask_out  = bus.write_mask_in;
            bus.ready_out       = slave_ready;
            if (slave_ready) begin
                bus.read_value_out = bus.slave_read_value_in[winner*32 +: 32];
            end
        end
    end

    assign bus.write_value_out = bus.write_value_in;

    // cnt counts cycles spent waiting on the selected slave; it is not restarted by address changes.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (access) begin
                    if (!hit_any) begin
                        state_next = ERR;
                    end else if (!slave_ready) begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (bus.ready_out || !access) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT)) begin
                    state_next = ERR;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ERR: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A new error outranks a simultaneous clear so the event that caused it is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_valid_out   <= 1'b0;
            err_timeout_out <= 1'b0;
            err_address_out <= 32'h0;
            err_count_out   <= 8'h0;
        end else if (err_enter) begin
            err_valid_out   <= 1'b1;
            err_timeout_out <= (state == WAIT);
            err_address_out <= bus.address_in;
            if (err_clear_in) begin
                err_count_out <= 8'd1;
            end else if (err_count_out != 8'hFF) begin
                err_count_out <= err_count_out + 8'd1;
            end
        end else if (err_clear_in) begin
            err_valid_out <= 1'b0;
            err_count_out <= 8'h0;
        end
    end
endmodule

// File: doc/mmio_interconnect.md
Name: mmio_interconnect

Overview:
Parametrised memory-mapped slave interconnect between the common memory bus (bus_arbiter output) and N peripherals, replacing hand-written casez decode and OR-reduced read/ready muxing at top level. Decodes address windows from base/mask parameters. Muxes the selected slave's read data and ready back to the master. Adds behaviour the fixed decoder lacks: an error response for unmapped addresses, a per-access timeout watchdog, and sticky error capture for firmware debug.

Parameters:
NUM_SLAVES, 9, number of slave ports (1..16)
SLAVE_BASE, packed NUM_SLAVES*32 bits, all 0, base address of slave i in bits [32*i+31:32*i]
SLAVE_MASK, packed NUM_SLAVES*32 bits, all 0, compare mask for slave i; hit when (address_in & mask) == (base & mask)
TIMEOUT, 255, max wait cycles before forced error completion; 0 disables the watchdog
ERR_VALUE, 32'hDEADBEEF, read data returned on an error completion

Ports:
clk  in  1  system clock (pll_clk domain)
reset  in  1  synchronous, active-high
address_in  in  32  master address
read_in  in  1  master read request, held until ready_out
write_in  in  1  master write request, held until ready_out
write_mask_in  in  4  byte write mask, passed through
write_value_in  in  32  write data, passed through
read_value_out  out  32  read data to master
ready_out  out  1  transaction completion
sel_out  out  NUM_SLAVES  one-hot slave select
slave_read_value_in  in  NUM_SLAVES*32  per-slave read data
slave_ready_in  in  NUM_SLAVES  per-slave ready
write_mask_out  out  4  equals write_mask_in gated by the active sel; 0 when no slave is selected
write_value_out  out  32  equals write_value_in
err_valid_out  out  1  sticky error flag
err_timeout_out  out  1  cause of last error: 1 = timeout, 0 = unmapped
err_address_out  out  32  address of last error
err_count_out  out  8  saturating error counter
err_clear_in  in  1  clears err_valid_out and err_count_out

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled only on posedge clk.
- Access: access = read_in | write_in.
- Decode: combinational. hit[i] = address match. Lowest index wins on overlap.
- Select: sel_out = onehot(winner) & access, forced to 0 in state ERR.
- Ready and read data, combinational in IDLE/WAIT:
  - ready_out = slave_ready_in[winner] & sel active.
  - read_value_out = slave_read_value_in[winner] when ready_out, else 0.
  - Read data is a true mux, not an OR; non-selected slaves cannot corrupt it.
- States: IDLE, WAIT, ERR. Counter cnt has width $clog2(TIMEOUT+1).
- IDLE:
  - access & no hit -> ERR.
  - access & hit & !slave ready -> WAIT, cnt = 1.
  - access & hit & ready -> stay IDLE; zero-wait completion.
- WAIT:
  - ready -> IDLE, cnt = 0.
  - !access (master abandoned) -> IDLE, no error.
  - TIMEOUT != 0 and cnt == TIMEOUT -> ERR.
  - Otherwise cnt++.
- ERR:
  - Exactly one cycle: ready_out = 1, read_value_out = ERR_VALUE, sel_out = 0 (write dropped).
  - Next state is IDLE unconditionally.
- Error capture, on ERR entry:
  - err_valid_out = 1, err_address_out = address_in.
  - err_timeout_out = 1 if entered from WAIT, 0 if entered from IDLE.
  - err_count_out increments, saturating at 255.
- err_clear_in: clears err_valid_out and err_count_out. A simultaneous ERR entry wins: flag = 1, count = 1, new address captured.
- Reset values: state IDLE, cnt 0, ready_out 0, read_value_out 0, sel_out 0, all err_* outputs 0.
  - Reset mid-WAIT aborts the access without error capture.
  - reset in the same cycle as ERR entry: reset wins.
- Back-to-back accesses: a new access the cycle after ready_out is decoded fresh from IDLE; no bubble is required.
- Address must be stable while access is high. An address change during WAIT is treated as the same access; cnt is not reset.

Test Plan:
- Zero-wait read: base0 = 0, mask0 = 32'hFFFF0000; read 0x00000010 with slave0 ready = 1, data 0x12345678 -> same-cycle ready_out = 1, read_value_out = 0x12345678, sel_out = 1, state stays IDLE.
- Wait states: slave 3 ready after 3 cycles -> ready_out only in 4th cycle, sel_out[3] held high throughout, no error.
- Unmapped: read 0x00090000 -> ready_out = 1 exactly one cycle later, read_value_out = 0xDEADBEEF, sel_out = 0 in that cycle, err_valid = 1, err_timeout = 0, err_address = 0x00090000, err_count = 1.
- Timeout: TIMEOUT = 4, slave never ready -> ERR at 5th cycle after request; ready_out = 1 with ERR_VALUE, err_timeout = 1. Same scenario with TIMEOUT = 0 -> no completion after 1000 cycles.
- Write to an unmapped address -> no sel_out pulse at any cycle, write_mask_out = 0, ready_out = 1 after one cycle.
- Clear vs error: err_clear_in asserted in the ERR-entry cycle -> err_valid = 1, err_count = 1. 300 unmapped accesses -> err_count = 255. Reset during WAIT -> all outputs 0 next cycle, err_valid = 0.
